def_cmd_arbiter: RTL

Shares one defectoscope command transmitter channel between two 32-bit command sources:
- Source 0: the NIOS command stream.
- Source 1: an auto source, e.g. way-sensor triggered commands.

The block arbitrates round-robin, holds the winning word until the transmitter accepts it, and then enforces a minimum inter-command gap. It sits between the NIOS cmd valid/ready port and the transmitter's din/validin/readyin, in the transmitter's clock domain.

---
 rtl/def_cmd_pkg.sv | 18 +
 rtl/rr_arb2.sv | 50 +++++
 rtl/def_cmd_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/def_cmd_pkg.sv
// Shared types and constants for the defectoscope command arbiter.
//   state_e    : arbiter FSM states (IDLE, SEND, GAP)
//   CMD_DATA_W : default command word width
//   SRC_NIOS / SRC_AUTO : source index values carried on tx_src
package def_cmd_pkg;

  localparam int unsigned CMD_DATA_W = 32;

  localparam logic SRC_NIOS = 1'b0;
  localparam logic SRC_AUTO = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
//   clk, rst      : clock, async active-high reset (pointer resets to SRC_AUTO
//                   so source 0 wins the first tie)
//   req0, req1    : request lines
//   take          : grant is being consumed this cycle; advance the pointer
//   gnt_any_c     : at least one request present (combinational)
//   gnt_src_c     : index of the source that would be granted (combinational)
module rr_arb2
  import def_cmd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt_any_c,
  output logic gnt_src_c
);

  logic last_q;
  logic last_d;

  // Grant selection; on a tie the source other than the last winner goes.
  always_comb begin
    gnt_any_c = req0 | req1;
    gnt_src_c = SRC_NIOS;
    if (req0 && req1) begin
      gnt_src_c = ~last_q;
    end else if (req1) begin
      gnt_src_c = SRC_AUTO;
    end
  end

  // Pointer only moves when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (take) begin
      last_d = gnt_src_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SRC_AUTO;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/def_cmd_arbiter.sv
// Shares one defectoscope command transmitter between the NIOS command stream
// (source 0) and an auto source (source 1). Round-robin grant, holds the word
// until the transmitter accepts it, then forces GAP_CYCLES idle cycles.
// Optional macro CMD_TIMEOUT_EN: abandon a word not accepted within
// TIMEOUT_CYCLES SEND cycles and raise the sticky err_timeout flag.
// Ports:
//   clk, rst               : transmitter-domain clock, async active-high reset
//   s0_valid/s0_data/s0_ready : NIOS source; ready pulses in the grant cycle
//   s1_valid/s1_data/s1_ready : auto source; ready pulses in the grant cycle
//   tx_valid/tx_data/tx_ready : transmitter handshake
//   tx_src                 : source index of the word on tx_data
//   busy                   : FSM not in IDLE
//   cnt0, cnt1             : per-source accepted command counters (wrapping)
//   err_timeout            : sticky timeout flag (0 when feature disabled)
module def_cmd_arbiter
  import def_cmd_pkg::*;
#(
  parameter int unsigned DATA_W         = CMD_DATA_W,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              tx_src,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              err_timeout
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

  if (DATA_W == 0 || CNT_W == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("def_cmd_arbiter: DATA_W, CNT_W and TIMEOUT_CYCLES must be non-zero");
  end

  state_e             state_q, state_d;
  logic               tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_src_q, tx_src_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic gnt_any;
  logic gnt_src;
  logic grant_take;
  logic timeout_hit;
  logic send_done;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (s0_valid),
    .req1      (s1_valid),
    .take      (grant_take),
    .gnt_any_c (gnt_any),
    .gnt_src_c (gnt_src)
  );

  // Next-state and datapath for IDLE -> SEND -> GAP -> IDLE.
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_src_d   = tx_src_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    gap_d      = gap_q;
    grant_take = 1'b0;
    send_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          grant_take = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = (gnt_src == SRC_AUTO) ? s1_data : s0_data;
          tx_src_d   = gnt_src;
          state_d    = SEND;
        end
      end

      SEND: begin
        // tx_valid is always high here, so tx_ready alone is the handshake.
        if (tx_ready) begin
          send_done  = 1'b1;
          tx_valid_d = 1'b0;
          if (tx_src_q == SRC_AUTO) begin
            cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          send_done  = 1'b1;
          tx_valid_d = 1'b0;
        end
        if (send_done) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES);
          end
        end
      end

      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_src_q   <= SRC_NIOS;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_src_q   <= tx_src_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      gap_q      <= gap_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  // Counts SEND cycles; fires on the last allowed cycle if tx_ready is still low.
  always_comb begin
    wait_d      = '0;
    err_d       = err_q;
    timeout_hit = 1'b0;
    if (state_q == SEND) begin
      wait_d = wait_q + WAIT_W'(1);
      if (!tx_ready && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
        timeout_hit = 1'b1;
        err_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Source ready is the grant itself, so the handover happens in the sampling cycle.
  assign s0_ready = grant_take & (gnt_src == SRC_NIOS) & ~rst;
  assign s1_ready = grant_take & (gnt_src == SRC_AUTO) & ~rst;

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_src   = tx_src_q;
  assign busy     = (state_q != IDLE);
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule
